// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 16x oversampling feeding a show-ahead receive FIFO
//
// Purpose: deserialises an asynchronous 8N1 line (LSB first, idle high) and
// queues good bytes in a small FIFO with sticky frame-error and overrun flags.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   uart_in      serial input line, asynchronous to clk
//   rd_en_i      pop request (ignored while empty)
//   clr_err_i    one-cycle pulse clearing frame_err_o and overrun_o
//   data_o       FIFO head byte (show-ahead)
//   empty_o      FIFO holds no bytes
//   full_o       FIFO holds DEPTH bytes
//   count_o      number of bytes held
//   frame_err_o  sticky: stop bit sampled low
//   overrun_o    sticky: good byte dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int DIV   = 27,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_in,
    input  logic                     rd_en_i,
    input  logic                     clr_err_i,
    output logic [7:0]               data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     frame_err_o,
    output logic                     overrun_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // synchronizer and line qualification
    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_sync_ok;
    logic               r_armed;
    logic               w_rx;

    // receiver datapath
    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic [3:0]         r_tick_cnt;
    logic [3:0]         w_tick_cnt_nxt;
    logic [2:0]         r_bit_cnt;
    logic [2:0]         w_bit_cnt_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               w_armed_nxt;
    logic               w_start_det;
    logic               w_push;
    logic               w_frame_set;

    // FIFO
    logic [7:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_wr;
    logic               w_ovr_set;
    logic               r_frame_err;
    logic               r_overrun;

    assign w_rx   = r_sync2;
    assign w_tick = (r_presc == PRESC_TOP);

    // r_sync_ok fills with ones two cycles after reset release; until then the
    // synchronizer still shows its reset value rather than the real line, so
    // it must not be taken as evidence of an idle-high line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_sync_ok <= 2'b00;
        end else begin
            r_sync1   <= uart_in;
            r_sync2   <= r_sync1;
            r_sync_ok <= {r_sync_ok[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_start_det || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_armed    <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_armed_nxt    = r_armed;
        w_start_det    = 1'b0;
        w_push         = 1'b0;
        w_frame_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A start edge is only accepted once the real line has been
                // seen high, so a line still low after an error or reset is
                // not mistaken for a new frame.
                if (r_sync_ok[1] && w_rx) begin
                    w_armed_nxt = 1'b1;
                end
                if (r_armed && !w_rx) begin
                    w_start_det    = 1'b1;
                    w_armed_nxt    = 1'b0;
                    w_tick_cnt_nxt = '0;
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd7) begin
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = w_rx ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    // 4-bit counter wraps 15->0, giving one sample per 16 ticks
                    w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd15) begin
                        w_shift_nxt   = {w_rx, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd15) begin
                        w_push      = w_rx;
                        w_frame_set = !w_rx;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_pop     = rd_en_i && !w_empty;
    // a simultaneous pop frees the slot, so a push while full still lands
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // set has priority over clear when both occur in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (clr_err_i) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_o      = r_mem[r_rd_ptr];
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign count_o     = r_count;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo (DIV=2, DEPTH=4)
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       uart_in;
    logic       rd_en_i;
    logic       clr_err_i;
    logic [7:0] data_o;
    logic       empty_o;
    logic       full_o;
    logic [2:0] count_o;
    logic       frame_err_o;
    logic       overrun_o;

    int n_checks;
    int n_fail;
    int push_cyc;

    uart_rx_fifo #(.DIV(2), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_in     (uart_in),
        .rd_en_i     (rd_en_i),
        .clr_err_i   (clr_err_i),
        .data_o      (data_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .count_o     (count_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One frame (start, 8 data LSB first, stop) at 32 clk/bit, then 32 clk idle.
    // Driven on negedges; cyc counts posedges since the start-bit drive.
    // pop_at: raise rd_en_i so it is high on posedge cyc=pop_at+1.
    // rst_at: pulse reset from that point for 4 clk and check reset outputs.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int pop_at, input int rst_at);
        logic [9:0] fr;
        logic       was_empty;
        int         cyc;
        fr        = {stop_bit, data, 1'b0};
        cyc       = 0;
        push_cyc  = 0;
        @(negedge clk);
        was_empty = empty_o;
        for (int b = 0; b < 11; b++) begin
            uart_in = (b == 10) ? 1'b1 : fr[b];
            repeat (32) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (push_cyc == 0 && was_empty && !empty_o) push_cyc = cyc;
                rd_en_i = (cyc == pop_at);
                if (rst_at != 0) begin
                    if (cyc == rst_at) rst = 1'b0;
                    if (cyc == rst_at + 2) begin
                        check("rst_mid_data",  data_o,      8'h00);
                        check("rst_mid_empty", empty_o,     1);
                        check("rst_mid_full",  full_o,      0);
                        check("rst_mid_count", count_o,     0);
                        check("rst_mid_ferr",  frame_err_o, 0);
                        check("rst_mid_ovr",   overrun_o,   0);
                    end
                    if (cyc == rst_at + 4) rst = 1'b1;
                end
            end
        end
        rd_en_i = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        uart_in   = 1'b1;
        rd_en_i   = 1'b0;
        clr_err_i = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_data",  data_o,      8'h00);
        check("reset_empty", empty_o,     1);
        check("reset_full",  full_o,      0);
        check("reset_count", count_o,     0);
        check("reset_ferr",  frame_err_o, 0);
        check("reset_ovr",   overrun_o,   0);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // single byte; stop midpoint is 304 clk after the start drive, plus
        // two synchronizer stages and the edge-detect cycle
        send_frame(8'hA5, 1'b1, 0, 0);
        check("a5_push_in_window", (push_cyc >= 303 && push_cyc <= 308), 1);
        check("a5_data",  data_o,  8'hA5);
        check("a5_count", count_o, 1);
        pop_one();
        check("a5_pop_empty", empty_o, 1);
        check("a5_pop_count", count_o, 0);

        // fill and overrun
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 0, 0);
            if (i == 4) begin
                check("fill_full4",  full_o,    1);
                check("fill_count4", count_o,   4);
                check("fill_ovr4",   overrun_o, 0);
            end
        end
        check("ovr_set",   overrun_o,   1);
        check("ovr_count", count_o,     4);
        check("ovr_ferr",  frame_err_o, 0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_read%0d", i), data_o, 8'(i));
            pop_one();
        end
        check("drain_empty", empty_o, 1);
        pop_one();
        check("underflow_count", count_o, 0);
        check("underflow_empty", empty_o, 1);
        clr_pulse();
        check("ovr_cleared", overrun_o, 0);

        // framing error
        send_frame(8'h3C, 1'b0, 0, 0);
        check("ferr_set",   frame_err_o, 1);
        check("ferr_count", count_o,     0);
        check("ferr_ovr",   overrun_o,   0);
        clr_pulse();
        check("ferr_cleared", frame_err_o, 0);

        // 10-clk glitch on idle line
        @(negedge clk);
        uart_in = 1'b0;
        repeat (10) @(negedge clk);
        uart_in = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_empty", empty_o,     1);
        check("glitch_ferr",  frame_err_o, 0);
        check("glitch_ovr",   overrun_o,   0);
        send_frame(8'h55, 1'b1, 0, 0);
        check("glitch_55_data",  data_o,  8'h55);
        check("glitch_55_count", count_o, 1);
        pop_one();

        // push and pop on the same edge while full
        send_frame(8'h10, 1'b1, 0, 0);
        send_frame(8'h20, 1'b1, 0, 0);
        send_frame(8'h30, 1'b1, 0, 0);
        send_frame(8'h40, 1'b1, 0, 0);
        check("pp_full_before", full_o, 1);
        send_frame(8'h66, 1'b1, 306, 0);
        check("pp_count", count_o,   4);
        check("pp_ovr",   overrun_o, 0);
        check("pp_full",  full_o,    1);
        check("pp_head",  data_o,    8'h20);
        pop_one();
        check("pp_rd30", data_o, 8'h30);
        pop_one();
        check("pp_rd40", data_o, 8'h40);
        pop_one();
        check("pp_tail66", data_o,  8'h66);
        check("pp_count1", count_o, 1);

        // reset during data bit 3 of a frame whose later bits keep the line low
        send_frame(8'h00, 1'b1, 0, 138);
        check("post_rst_empty", empty_o,     1);
        check("post_rst_ferr",  frame_err_o, 0);
        check("post_rst_ovr",   overrun_o,   0);
        send_frame(8'hC3, 1'b1, 0, 0);
        check("c3_data",  data_o,      8'hC3);
        check("c3_count", count_o,     1);
        check("c3_ferr",  frame_err_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
